// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter in front of a shared 32-bit add/sub/and/or ALU.
// Registered result with NZCV flags and requester tag; bounded lock for dependent sequences.
module alu_share_arb #(
   parameter int LOCK_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [1:0]  req0_ctrl,
   input  logic        req0_lock,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [1:0]  req1_ctrl,
   input  logic        req1_lock,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        rsp_id
);
   localparam int CW = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

   state_t          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            gnt0, gnt1, sel, xfer;
   logic [31:0]     op_a, op_b, bx, res;
   logic [1:0]      op;
   logic            op_lock, c_f, v_f;
   logic [32:0]     sum;
   logic [31:0]     rsp_result_q, rsp_result_d;
   logic [3:0]      rsp_flags_q, rsp_flags_d;
   logic            rsp_id_q, rsp_id_d;
   logic            rsp0_valid_q, rsp1_valid_q;

   // Grant: the lock owner is the only candidate, otherwise ptr breaks ties.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state_q)
         LOCK0:   gnt0 = req0_valid;
         LOCK1:   gnt1 = req1_valid;
         default: begin
            if (req0_valid && (!req1_valid || !ptr_q)) gnt0 = 1'b1;
            else if (req1_valid)                      gnt1 = 1'b1;
         end
      endcase
   end

   assign sel        = gnt1;
   assign xfer       = gnt0 | gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign op_a    = sel ? req1_a    : req0_a;
   assign op_b    = sel ? req1_b    : req0_b;
   assign op      = sel ? req1_ctrl : req0_ctrl;
   assign op_lock = sel ? req1_lock : req0_lock;

   assign bx  = op[0] ? ~op_b : op_b;
   assign sum = {1'b0, op_a} + {1'b0, bx} + {32'b0, op[0]};

   always_comb begin
      res = sum[31:0];
      c_f = 1'b0;
      v_f = 1'b0;
      case (op)
         2'b10:   res = op_a & op_b;
         2'b11:   res = op_a | op_b;
         default: begin
            c_f = sum[32];
            // Subtract overflows when operand signs differ; add when they match.
            v_f = ((op_a[31] ^ op_b[31]) == op[0]) && (res[31] != op_a[31]);
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      cnt_inc      = cnt_q + CW'(1);
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_id_d     = rsp_id_q;
      if (xfer) begin
         ptr_d        = ~sel;
         rsp_result_d = res;
         rsp_flags_d  = {res[31], (res == 32'd0), c_f, v_f};
         rsp_id_d     = sel;
         if (state_q == ARB) begin
            if (op_lock && (LOCK_MAX > 1)) begin
               state_d = sel ? LOCK1 : LOCK0;
               cnt_d   = CW'(1);
            end
         end else if (!op_lock || (cnt_inc == CW'(LOCK_MAX))) begin
            state_d = ARB;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB;
         cnt_q        <= '0;
         ptr_q        <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_id_q     <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_id_q     <= rsp_id_d;
         rsp0_valid_q <= gnt0;
         rsp1_valid_q <= gnt1;
      end
   end

   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_id     = rsp_id_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized traffic checked
// against an owner/count/pointer reference model and a wide-arithmetic ALU model.
module tb_alu_share_arb;
   localparam int LOCK_MAX = 4;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req0_valid = 0, req1_valid = 0, req0_lock = 0, req1_lock = 0;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [1:0]  req0_ctrl = 0, req1_ctrl = 0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_id;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;

   int vectors = 0, miscompares = 0;

   // reference model state
   int          m_owner, m_cnt;
   logic        m_ptr;
   logic        exp_v0, exp_v1, exp_id;
   logic [31:0] exp_res;
   logic [3:0]  exp_flags;

   alu_share_arb #(.LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl), .req0_lock(req0_lock),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl), .req1_lock(req1_lock),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_id(rsp_id)
   );

   always #5 clk = ~clk;

   function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      logic [31:0] r;
      logic        c, v;
      longint      sa, sb, s;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      c = 0; v = 0; s = 0;
      case (op)
         2'd0: begin r = a + b; c = (longint'(a) + longint'(b)) > 64'hFFFF_FFFF; s = sa + sb; end
         2'd1: begin r = a - b; c = (a >= b); s = sa - sb; end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      if (op[1] == 1'b0) v = (s != longint'(signed'(r)));
      return {r[31], (r == 0), c, v, r};
   endfunction

   function automatic logic [1:0] m_grant(input logic v0, input logic v1);
      if (m_owner == 0) return {1'b0, v0};
      if (m_owner == 1) return {v1, 1'b0};
      if (v0 && v1)     return m_ptr ? 2'b10 : 2'b01;
      return {v1, v0};
   endfunction

   task automatic m_reset();
      m_owner = -1; m_cnt = 0; m_ptr = 0;
      exp_v0 = 0; exp_v1 = 0; exp_id = 0; exp_res = 0; exp_flags = 0;
   endtask

   task automatic m_xfer(input int i, input logic lk, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
      logic [35:0] f;
      f = alu_ref(a, b, op);
      exp_res = f[31:0]; exp_flags = f[35:32]; exp_id = (i == 1);
      m_ptr = (i == 0);
      if (m_owner < 0) begin
         if (lk && LOCK_MAX > 1) begin m_owner = i; m_cnt = 1; end
      end else begin
         m_cnt++;
         if (!lk || m_cnt == LOCK_MAX) begin m_owner = -1; m_cnt = 0; end
      end
   endtask

   // one clock with the current inputs; advances the model, leaves time at edge+1
   task automatic tick();
      logic [1:0] g;
      g = m_grant(req0_valid, req1_valid);
      @(posedge clk);
      exp_v0 = g[0]; exp_v1 = g[1];
      if (g[0])      m_xfer(0, req0_lock, req0_a, req0_b, req0_ctrl);
      else if (g[1]) m_xfer(1, req1_lock, req1_a, req1_b, req1_ctrl);
      #1;
   endtask

   task automatic test_reset();
      m_reset();
      #3;
      vectors++;
      if ({rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result, req0_ready, req1_ready} !== '0) begin
         miscompares++; $display("FAIL reset_initial got %h required 0",
            {rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result, req0_ready, req1_ready});
      end
      rst_n = 1;
      req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = 0;
      tick();
      req1_valid = 1; req1_a = 9; req1_b = 1;
      #3 rst_n = 0;
      #1;
      m_reset();
      vectors++;
      if ({rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result} !== '0) begin
         miscompares++; $display("FAIL reset_async got %h required 0",
            {rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result});
      end
      req0_valid = 0; req1_valid = 0;
      #2 rst_n = 1;
      req1_valid = 1;
      #1;
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         miscompares++; $display("FAIL reset_release_ready got %b required 01", {req0_ready, req1_ready});
      end
      tick();
      vectors++;
      if (rsp1_valid !== 1'b1 || rsp_result !== 32'd10) begin
         miscompares++; $display("FAIL reset_first_rsp got v=%b r=%h required v=1 r=0000000a", rsp1_valid, rsp_result);
      end
      req1_valid = 0;
   endtask

   task automatic test_single();
      req0_valid = 1; req0_ctrl = 2'b01; req0_a = 5; req0_b = 7; req0_lock = 0;
      tick();
      req0_valid = 0;
      vectors++;
      if ({rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result} !== {3'b100, 4'b1000, 32'hFFFF_FFFE}) begin
         miscompares++; $display("FAIL single_sub got v0=%b v1=%b id=%b f=%b r=%h required 1 0 0 1000 fffffffe",
            rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result);
      end
   endtask

   task automatic test_flags();
      logic [31:0] ta [4] = '{32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'h0F};
      logic [31:0] tb [4] = '{32'd1, 32'd3, 32'd1, 32'hF0};
      logic [1:0]  tc [4] = '{2'b00, 2'b01, 2'b00, 2'b11};
      logic [31:0] tr [4] = '{32'h8000_0000, 32'd0, 32'd0, 32'hFF};
      logic [3:0]  tf [4] = '{4'b1001, 4'b0110, 4'b0110, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1; req0_a = ta[i]; req0_b = tb[i]; req0_ctrl = tc[i];
         tick();
         vectors++;
         if (rsp_result !== tr[i] || rsp_flags !== tf[i]) begin
            miscompares++; $display("FAIL flags_%0d got r=%h f=%b required r=%h f=%b",
               i, rsp_result, rsp_flags, tr[i], tf[i]);
         end
      end
      req0_valid = 0;
      tick();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_result !== 32'hFF) begin
         miscompares++; $display("FAIL idle_hold got v=%b%b r=%h required 00 r=000000ff",
            rsp0_valid, rsp1_valid, rsp_result);
      end
   endtask

   task automatic test_fairness();
      // one req1 transfer so req0 holds priority going in
      req1_valid = 1; req1_ctrl = 0; req1_a = 1; req1_b = 1; req1_lock = 0;
      tick();
      req0_valid = 1; req0_ctrl = 0; req0_lock = 0;
      for (int k = 0; k < 6; k++) begin
         req0_a = k; req0_b = 100; req1_a = k; req1_b = 200;
         #1;
         vectors++;
         if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            miscompares++; $display("FAIL fair_grant_%0d got %b%b required %s", k, req1_ready, req0_ready,
               (k % 2 == 0) ? "01" : "10");
         end
         tick();
         vectors++;
         if ({rsp1_valid, rsp0_valid} !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
             rsp_result !== ((k % 2 == 0) ? k + 100 : k + 200)) begin
            miscompares++; $display("FAIL fair_rsp_%0d got v=%b%b r=%0d", k, rsp1_valid, rsp0_valid, rsp_result);
         end
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_lock_bound();
      int n0;
      n0 = 0;
      req0_lock = 1; req0_ctrl = 0; req1_ctrl = 1; req1_lock = 0;
      req1_valid = 1;
      for (int c = 0; c < 6; c++) begin
         req0_valid = (c != 2);
         req0_a = c; req0_b = 1; req1_a = 50; req1_b = c;
         #1;
         vectors++;
         if ({req1_ready, req0_ready} !== ((c == 2) ? 2'b00 : (c == 5) ? 2'b10 : 2'b01)) begin
            miscompares++; $display("FAIL lock_grant_%0d got %b%b required %s", c, req1_ready, req0_ready,
               (c == 2) ? "00" : (c == 5) ? "10" : "01");
         end
         tick();
         if (rsp0_valid) n0++;
      end
      vectors++;
      if (n0 !== 4) begin
         miscompares++; $display("FAIL lock_count got %0d required 4", n0);
      end
      vectors++;
      if (rsp1_valid !== 1'b1 || rsp_result !== 32'd45 || rsp_id !== 1'b1) begin
         miscompares++; $display("FAIL lock_release_rsp got v1=%b r=%0d id=%b required 1 45 1",
            rsp1_valid, rsp_result, rsp_id);
      end
      req0_valid = 0; req1_valid = 0; req0_lock = 0;
   endtask

   task automatic test_reset_lock();
      req1_valid = 1; req1_lock = 1; req1_ctrl = 0; req1_a = 2; req1_b = 3;
      tick();
      req0_valid = 1; req0_lock = 0; req0_a = 11; req0_b = 22;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         miscompares++; $display("FAIL rlock_grant got %b%b required 10", req1_ready, req0_ready);
      end
      #1 rst_n = 0;
      m_reset();
      @(posedge clk);
      #1;
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         miscompares++; $display("FAIL rlock_no_rsp got %b%b required 00", rsp0_valid, rsp1_valid);
      end
      req1_valid = 0; req1_lock = 0;
      #2 rst_n = 1;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         miscompares++; $display("FAIL rlock_after_ready got %b%b required 01", req1_ready, req0_ready);
      end
      tick();
      vectors++;
      if (rsp0_valid !== 1'b1 || rsp_result !== 32'd33 || rsp_id !== 1'b0) begin
         miscompares++; $display("FAIL rlock_after_rsp got v0=%b r=%0d id=%b required 1 33 0",
            rsp0_valid, rsp_result, rsp_id);
      end
      req0_valid = 0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_lock  = ($urandom_range(0, 2) != 0);
         req1_lock  = ($urandom_range(0, 2) != 0);
         req0_ctrl  = 2'($urandom); req1_ctrl = 2'($urandom);
         req0_a = pick(); req0_b = pick(); req1_a = pick(); req1_b = pick();
         #1;
         vectors++;
         if ({req1_ready, req0_ready} !== m_grant(req0_valid, req1_valid)) begin
            miscompares++; $display("FAIL rand_grant_%0d got %b%b required %b", k, req1_ready, req0_ready,
               m_grant(req0_valid, req1_valid));
         end
         tick();
         vectors++;
         if ({rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result} !==
             {exp_v0, exp_v1, exp_id, exp_flags, exp_res}) begin
            miscompares++; $display("FAIL rand_rsp_%0d got v=%b%b id=%b f=%b r=%h required v=%b%b id=%b f=%b r=%h",
               k, rsp0_valid, rsp1_valid, rsp_id, rsp_flags, rsp_result,
               exp_v0, exp_v1, exp_id, exp_flags, exp_res);
         end
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_flags();
      test_fairness();
      test_lock_bound();
      test_reset_lock();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port round-robin arbiter that shares one 32-bit add/sub/and/or ALU between two requesters, for example the execute stage and an address-generation or multi-word helper. It accepts at most one operation per cycle and registers the result with NZCV flags and a requester tag. A lock mechanism lets one requester issue back-to-back dependent operations, such as multi-word arithmetic, with a bounded hold time so the other requester is never starved.

## Interface
- `LOCK_MAX`, default 4: maximum consecutive transfers one requester may hold under lock. Legal range is ≥1. A value of 1 disables locking.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: operation request.
- `req0_ready` / `req1_ready` out 1: grant. A transfer occurs when `valid & ready`.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in 32: operands.
- `req0_ctrl` / `req1_ctrl` in 2: operation select. 00 = a+b, 01 = a−b, 10 = a&b, 11 = a|b.
- `req0_lock` / `req1_lock` in 1: request to keep the grant after this transfer. Sampled only on a transfer.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle pulse, the result for that requester is on `rsp_*`.
- `rsp_result` out 32: registered ALU result.
- `rsp_flags` out 4: registered {N,Z,C,V}.
- `rsp_id` out 1: requester index of the last transfer.

## Operation
- **ALU function (combinational on the granted operands):**
  - Add/sub are computed as a + (ctrl[0] ? ~b : b) + ctrl[0] with a 33-bit sum.
  - N = result[31].
  - Z = (result == 0).
  - C = bit 32 of the sum, add/sub only. For sub, C=1 means no borrow (a ≥ b unsigned).
  - V, add: a and b have the same sign and the result sign differs from a.
  - V, sub: a and b have different signs and the result sign differs from a.
  - For and/or: C = V = 0.
- **State:**
  - `ptr`: priority requester.
  - FSM: ARB, LOCK0, LOCK1.
  - `lock_cnt`: width ⌈log2(LOCK_MAX+1)⌉.
- **Grant in ARB:**
  - Only one valid: grant it.
  - Both valid: grant `ptr`.
  - `reqN_ready` is high only when `reqN_valid` is high. There is a combinational valid→ready path.
- **Grant in LOCKn:**
  - Only requester n can be granted, and only when `reqn_valid` is high.
  - The other requester's ready is 0 even if requester n is idle that cycle.
- **On every transfer by requester i:** `ptr` ← ~i.
- **FSM transitions:**
  - ARB, transfer by i with lock=1 and LOCK_MAX>1 → LOCKi, `lock_cnt`=1.
  - ARB, any other transfer → stay in ARB.
  - LOCKi, transfer by i: `lock_cnt`+1. If lock=0 or the new count equals LOCK_MAX → ARB with `lock_cnt`=0; otherwise stay in LOCKi.
  - LOCKi, no transfer: hold state and count. There is no timeout.
- **Response:**
  - On a transfer, the next edge loads `rsp_result`, `rsp_flags` and `rsp_id`, and pulses `rspi_valid` for one cycle.
  - Without a transfer, `rsp_*` hold their values and both `rsp_valid` are 0.
  - There is no response backpressure.
- **Reset:** clears everything immediately, including any lock in progress. An operation transferred in the cycle the reset asserts produces no response.

## Timing
- Throughput is 1 operation per cycle.
- Latency is 1: a transfer at edge k appears on `rsp_*` / `rspi_valid` after edge k.
- Reset values:
  - All `rsp_*` = 0.
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `ptr` = 0, FSM = ARB, `lock_cnt` = 0.
  - `reqN_ready` follows from these values (0 when its valid is low).
- Simultaneous valid with lock=1 from both requesters in ARB: only the granted requester's lock is honoured.
- LOCK_MAX=1: the FSM never leaves ARB, and lock is ignored.
- The lock is released at the transfer that makes `lock_cnt`=LOCK_MAX. The other requester, if valid, is granted on the very next cycle.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-stream → all outputs 0 asynchronously. After release with only `req1_valid`=1, `req1_ready`=1 in the same cycle.
2. **Single op:** req0 sub, a=5, b=7 → next cycle `rsp0_valid`=1, `rsp_result`=0xFFFFFFFE, `rsp_flags`=4'b1000, `rsp_id`=0.
3. **Flags:**
   - add 0x7FFFFFFF+1 → 0x80000000, flags 1001.
   - sub 3−3 → 0, flags 0110.
   - add 0xFFFFFFFF+1 → 0, flags 0110.
   - or 0x0F|0xF0 → 0xFF, flags 0000.
4. **Fairness:** both valid continuously for 6 cycles, no lock → grants 0,1,0,1,0,1. Each `rspi_valid` alternates one cycle later.
5. **Lock bound:** LOCK_MAX=4, req0 lock=1 held, req1 valid held, req0 valid dropped for one cycle mid-lock.
   - req0 gets exactly 4 transfers.
   - `req1_ready`=0 throughout the lock, including the idle cycle.
   - req1 is granted on the cycle after the 4th transfer.
6. **Reset during lock:** in LOCK1 with a transfer in the same cycle, assert reset → no `rsp1_valid` afterwards. After release, req0 alone is granted immediately.
